// File: rtl/i2c_slave_if.sv
// ============================================================================
// Module      : i2c_slave_if
// Description : I2C slave endpoint with 7-bit address match, write capture and
//               FIFO-backed read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_if #(
    parameter int ADDR_WIDTH          = 2,
    parameter int DATA_WIDTH          = 8,
    parameter int TRANSFER_DEBUG_MODE = 0,
    parameter int TX_DEPTH            = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    input  logic [6:0]            slave_addr_i,
    input  logic                  tx_push_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_flush_i,
    output logic [DATA_WIDTH-1:0] most_recent_xfer,
    output logic                  xfer_valid_o,
    output logic                  xfer_dir_o,
    output logic                  tx_empty_o,
    output logic                  tx_full_o,
    output logic                  busy_o
);

    localparam int c_PTR_W = $clog2(TX_DEPTH);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ADDR     = 3'd1;
    localparam logic [2:0] c_ADDR_ACK = 3'd2;
    localparam logic [2:0] c_WR_DATA  = 3'd3;
    localparam logic [2:0] c_WR_ACK   = 3'd4;
    localparam logic [2:0] c_RD_DATA  = 3'd5;
    localparam logic [2:0] c_RD_ACK   = 3'd6;
    localparam logic [2:0] c_IGNORE   = 3'd7;

    // Host address width and debug mode have no bearing on the datapath.
    if (ADDR_WIDTH < 1 || TRANSFER_DEBUG_MODE < 0) begin : g_param_guard
    end

    logic w_scl_in, w_sda_in;
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    logic [2:0]            r_state, w_state_next;
    logic [3:0]            r_cnt, w_cnt_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic [DATA_WIDTH-1:0] r_tx_byte, w_tx_next;
    logic [DATA_WIDTH-1:0] r_xfer, w_xfer_next;
    logic                  r_drive, w_drive_next;
    logic                  r_busy, w_busy_next;
    logic                  r_rw, w_rw_next;
    logic                  r_valid, w_valid_next;
    logic                  r_dir, w_dir_next;
    logic                  w_pop;

    logic [DATA_WIDTH-1:0] r_mem [TX_DEPTH];
    logic [c_PTR_W:0]      r_wr_ptr, r_rd_ptr;
    logic                  w_empty, w_full, w_do_push, w_do_pop;
    logic [DATA_WIDTH-1:0] w_head;

    // Unknown or floating pins resolve to the pulled-up level.
    assign w_scl_in = (scl_i === 1'b0) ? 1'b0 : 1'b1;
    assign w_sda_in = (sda_i === 1'b0) ? 1'b0 : 1'b1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= w_scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= w_sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_head    = w_empty ? {DATA_WIDTH{1'b1}} : r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign w_do_push = tx_push_i & ~w_full & ~tx_flush_i;
    assign w_do_pop  = w_pop & ~w_empty & ~tx_flush_i;

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (tx_flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_tx_byte <= '0;
            r_xfer    <= '0;
            r_drive   <= 1'b0;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_valid   <= 1'b0;
            r_dir     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_shift   <= w_shift_next;
            r_tx_byte <= w_tx_next;
            r_xfer    <= w_xfer_next;
            r_drive   <= w_drive_next;
            r_busy    <= w_busy_next;
            r_rw      <= w_rw_next;
            r_valid   <= w_valid_next;
            r_dir     <= w_dir_next;
        end
    end

    // r_cnt counts SCL rises in the current byte: 1..8 are data, 9 is the ACK slot.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_tx_next    = r_tx_byte;
        w_xfer_next  = r_xfer;
        w_drive_next = r_drive;
        w_busy_next  = r_busy;
        w_rw_next    = r_rw;
        w_valid_next = 1'b0;
        w_dir_next   = r_dir;
        w_pop        = 1'b0;
        if (w_start) begin
            w_state_next = c_ADDR;
            w_cnt_next   = '0;
            w_drive_next = 1'b0;
        end else if (w_stop) begin
            w_state_next = c_IDLE;
            w_drive_next = 1'b0;
            w_busy_next  = 1'b0;
        end else begin
            if (w_scl_rise && r_state != c_IDLE && r_state != c_IGNORE) begin
                w_cnt_next   = r_cnt + 4'd1;
                w_shift_next = {r_shift[DATA_WIDTH-2:0], r_sda_s2};
            end
            case (r_state)
                c_ADDR: begin
                    if (w_scl_fall && r_cnt == 4'd8) begin
                        if (r_shift[7:1] == slave_addr_i) begin
                            w_state_next = c_ADDR_ACK;
                            w_drive_next = 1'b1;
                            w_busy_next  = 1'b1;
                            w_rw_next    = r_shift[0];
                        end else begin
                            w_state_next = c_IGNORE;
                            w_busy_next  = 1'b0;
                        end
                    end
                end
                c_ADDR_ACK: begin
                    if (w_scl_fall && r_cnt == 4'd9) begin
                        w_cnt_next = '0;
                        if (r_rw) begin
                            w_state_next = c_RD_DATA;
                            w_pop        = 1'b1;
                            w_tx_next    = w_head;
                            w_drive_next = ~w_head[7];
                        end else begin
                            w_state_next = c_WR_DATA;
                            w_drive_next = 1'b0;
                        end
                    end
                end
                c_WR_DATA: begin
                    if (w_scl_fall && r_cnt == 4'd8) begin
                        w_state_next = c_WR_ACK;
                        w_xfer_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_dir_next   = 1'b0;
                        w_drive_next = 1'b1;
                    end
                end
                c_WR_ACK: begin
                    if (w_scl_fall && r_cnt == 4'd9) begin
                        w_state_next = c_WR_DATA;
                        w_cnt_next   = '0;
                        w_drive_next = 1'b0;
                    end
                end
                c_RD_DATA: begin
                    if (w_scl_fall && r_cnt == 4'd8) begin
                        w_state_next = c_RD_ACK;
                        w_drive_next = 1'b0;
                        w_xfer_next  = r_tx_byte;
                        w_valid_next = 1'b1;
                        w_dir_next   = 1'b1;
                    end else if (w_scl_fall && r_cnt != 4'd0) begin
                        w_drive_next = ~r_tx_byte[3'd7 - r_cnt[2:0]];
                    end
                end
                c_RD_ACK: begin
                    // After the 9th rise the master's ACK/NACK sits in r_shift[0].
                    if (w_scl_fall && r_cnt == 4'd9) begin
                        w_cnt_next = '0;
                        if (!r_shift[0]) begin
                            w_state_next = c_RD_DATA;
                            w_pop        = 1'b1;
                            w_tx_next    = w_head;
                            w_drive_next = ~w_head[7];
                        end else begin
                            w_state_next = c_IGNORE;
                            w_drive_next = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_o            = r_drive ? 1'b0 : 1'bz;
    assign most_recent_xfer = r_xfer;
    assign xfer_valid_o     = r_valid;
    assign xfer_dir_o       = r_dir;
    assign tx_empty_o       = w_empty;
    assign tx_full_o        = w_full;
    assign busy_o           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_if.sv
// ============================================================================
// Module      : tb_i2c_slave_if
// Description : Directed bench for i2c_slave_if: two slaves on one bus driven
//               by a bit-banged master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave_if;

    localparam int c_HALF = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    wire sda_bus;
    pullup (sda_bus);
    assign sda_bus = sda_m ? 1'bz : 1'b0;

    logic [6:0] addr0 = 7'h12;
    logic [6:0] addr1 = 7'h13;
    logic       push0 = 1'b0, flush0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       push1 = 1'b0, flush1 = 1'b0;
    logic [7:0] data1 = 8'h00;

    logic [7:0] recent0, recent1;
    logic       valid0, valid1, dir0, dir1, empty0, empty1, full0, full1, busy0, busy1;

    i2c_slave_if u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_bus),
        .slave_addr_i(addr0), .tx_push_i(push0), .tx_data_i(data0), .tx_flush_i(flush0),
        .most_recent_xfer(recent0), .xfer_valid_o(valid0), .xfer_dir_o(dir0),
        .tx_empty_o(empty0), .tx_full_o(full0), .busy_o(busy0)
    );

    i2c_slave_if u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_bus),
        .slave_addr_i(addr1), .tx_push_i(push1), .tx_data_i(data1), .tx_flush_i(flush1),
        .most_recent_xfer(recent1), .xfer_valid_o(valid1), .xfer_dir_o(dir1),
        .tx_empty_o(empty1), .tx_full_o(full1), .busy_o(busy1)
    );

    int unsigned vcnt0 = 0;
    int unsigned vcnt1 = 0;
    always @(posedge clk) begin
        if (valid0) vcnt0 <= vcnt0 + 1;
        if (valid1) vcnt1 <= vcnt1 + 1;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        wait_clk(c_HALF);
        scl_m = 1'b1;
        wait_clk(c_HALF);
        scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1;
        wait_clk(c_HALF);
        scl_m = 1'b1;
        wait_clk(c_HALF / 2);
        b = sda_bus;
        wait_clk(c_HALF / 2);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(c_HALF);
        scl_m = 1'b1;
        wait_clk(c_HALF);
        sda_m = 1'b0;
        wait_clk(c_HALF);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(c_HALF);
        scl_m = 1'b1;
        wait_clk(c_HALF);
        sda_m = 1'b1;
        wait_clk(c_HALF);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bit_v);
            b[i] = bit_v;
        end
        send_bit(nack);
    endtask

    task automatic push_byte(input logic [7:0] d);
        data0 = d;
        push0 = 1'b1;
        wait_clk(1);
        push0 = 1'b0;
    endtask

    logic        ack;
    logic [7:0]  rd;
    int unsigned v0_snap, v1_snap;

    initial begin
        // Reset state
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        check("rst_recent", recent0, 8'h00);
        check("rst_valid", valid0, 1'b0);
        check("rst_dir", dir0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_empty", empty0, 1'b1);
        check("rst_full", full0, 1'b0);
        check("rst_bus", sda_bus, 1'b1);

        // Eight master writes to 0x12
        i2c_start();
        write_byte(8'h24, ack);
        check("wr_addr_ack", ack, 1'b0);
        check("wr_busy", busy0, 1'b1);
        v0_snap = vcnt0;
        for (int i = 0; i < 8; i++) begin
            write_byte(8'(i), ack);
            check("wr_data_ack", ack, 1'b0);
            check("wr_recent", recent0, 32'(i));
            check("wr_dir", dir0, 1'b0);
        end
        i2c_stop();
        check("wr_pulses", vcnt0 - v0_snap, 32'd8);
        check("wr_busy_after_stop", busy0, 1'b0);

        // Eight master reads from preloaded FIFO
        for (int i = 8; i < 16; i++) push_byte(8'(i));
        check("rd_not_empty", empty0, 1'b0);
        v0_snap = vcnt0;
        i2c_start();
        write_byte(8'h25, ack);
        check("rd_addr_ack", ack, 1'b0);
        for (int i = 0; i < 8; i++) begin
            read_byte(rd, (i == 7));
            check("rd_data", rd, 32'(8 + i));
        end
        i2c_stop();
        check("rd_empty", empty0, 1'b1);
        check("rd_dir", dir0, 1'b1);
        check("rd_recent", recent0, 8'h0F);
        check("rd_pulses", vcnt0 - v0_snap, 32'd8);

        // Second instance at 0x13 is the only responder to 0x26
        v0_snap = vcnt0;
        v1_snap = vcnt1;
        i2c_start();
        write_byte(8'h26, ack);
        check("two_ack", ack, 1'b0);
        check("two_busy0", busy0, 1'b0);
        check("two_busy1", busy1, 1'b1);
        write_byte(8'hA5, ack);
        check("two_data_ack", ack, 1'b0);
        check("two_recent1", recent1, 8'hA5);
        i2c_stop();
        check("two_busy1_stop", busy1, 1'b0);
        check("two_pulse0", vcnt0 - v0_snap, 32'd0);
        check("two_pulse1", vcnt1 - v1_snap, 32'd1);

        // Unknown address
        v0_snap = vcnt0;
        v1_snap = vcnt1;
        i2c_start();
        write_byte(8'hA0, ack);
        check("unk_nack", ack, 1'b1);
        write_byte(8'h00, ack);
        check("unk_data_nack", ack, 1'b1);
        check("unk_busy", busy0, 1'b0);
        i2c_stop();
        check("unk_pulse0", vcnt0 - v0_snap, 32'd0);
        check("unk_pulse1", vcnt1 - v1_snap, 32'd0);

        // Write, repeated START, read: alternating direction
        for (int i = 0; i < 8; i++) push_byte(8'(8'h30 + i));
        for (int i = 0; i < 8; i++) begin
            i2c_start();
            write_byte(8'h24, ack);
            check("alt_wa_ack", ack, 1'b0);
            write_byte(8'h05, ack);
            check("alt_w_ack", ack, 1'b0);
            check("alt_w_dir", dir0, 1'b0);
            check("alt_w_recent", recent0, 8'h05);
            i2c_start();
            write_byte(8'h25, ack);
            check("alt_ra_ack", ack, 1'b0);
            read_byte(rd, 1'b1);
            check("alt_r_data", rd, 32'(8'h30 + i));
            check("alt_r_dir", dir0, 1'b1);
            check("alt_r_recent", recent0, 32'(8'h30 + i));
        end
        i2c_stop();
        check("alt_empty", empty0, 1'b1);

        // Read with an empty FIFO returns 0xFF
        i2c_start();
        write_byte(8'h25, ack);
        check("emp_addr_ack", ack, 1'b0);
        read_byte(rd, 1'b1);
        check("emp_data", rd, 8'hFF);
        check("emp_recent", recent0, 8'hFF);
        i2c_stop();

        // Async reset while the slave is driving a read bit
        push_byte(8'h00);
        push_byte(8'h11);
        i2c_start();
        write_byte(8'h25, ack);
        check("ar_addr_ack", ack, 1'b0);
        wait_clk(8);
        check("ar_driving", sda_bus, 1'b0);
        check("ar_busy", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ar_released", sda_bus, 1'b1);
        check("ar_busy_clr", busy0, 1'b0);
        check("ar_fifo_clr", empty0, 1'b1);
        wait_clk(2);
        rst_n = 1'b1;
        i2c_stop();

        // FIFO full, dropped push, flush beats push
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("fifo_full", full0, 1'b1);
        check("fifo_not_empty", empty0, 1'b0);
        push_byte(8'hEE);
        check("fifo_still_full", full0, 1'b1);
        data0  = 8'h77;
        push0  = 1'b1;
        flush0 = 1'b1;
        wait_clk(1);
        push0  = 1'b0;
        flush0 = 1'b0;
        wait_clk(1);
        check("flush_empty", empty0, 1'b1);
        check("flush_not_full", full0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
